// File: rtl/seq_alu.sv
// seq_alu: handshaked execute-stage ALU.
// Base RV32I ops complete in one cycle; RV32M multiply/divide run an
// iterative one-bit-per-cycle datapath with a fixed XLEN+2 cycle latency.
module seq_alu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int SHW  = $clog2(XLEN);
   localparam int CNTW = $clog2(XLEN) + 1;

   // base op codes (op[3:0] with op[4]=0)
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b0110;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;

   // M op codes (op[2:0] with op[4]=1)
   localparam logic [2:0] FN_MUL    = 3'b000;
   localparam logic [2:0] FN_MULH   = 3'b001;
   localparam logic [2:0] FN_MULHSU = 3'b010;
   localparam logic [2:0] FN_MULHU  = 3'b011;
   localparam logic [2:0] FN_DIV    = 3'b100;
   localparam logic [2:0] FN_DIVU   = 3'b101;
   localparam logic [2:0] FN_REM    = 3'b110;
   localparam logic [2:0] FN_REMU   = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIN  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t state_q, state_d;

   // datapath state: hi/lo form the 2*XLEN product, or remainder/quotient
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;          // multiplicand or divisor magnitude
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [2:0]      fn_q, fn_d;
   logic            neg_q, neg_d;      // product / quotient needs negation
   logic            rneg_q, rneg_d;    // remainder needs negation (dividend sign)
   logic            dz_q, dz_d;        // divide by zero
   logic [XLEN-1:0] result_q, result_d;

   logic            accept;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] base_res;
   logic            m_s1, m_s2;
   logic            neg1, neg2;
   logic [XLEN-1:0] mag1, mag2;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_rs;
   logic [XLEN:0]   div_diff;
   logic            div_ge;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0] quot, rem, fin_res;

   assign accept = (state_q == S_IDLE) && in_valid && !rst;
   assign shamt  = op2[SHW-1:0];

   // single-cycle base operations
   always_comb begin
      base_res = '0;
      case (op[3:0])
         OP_ADD:  base_res = op1 + op2;
         OP_SUB:  base_res = op1 - op2;
         OP_AND:  base_res = op1 & op2;
         OP_OR:   base_res = op1 | op2;
         OP_XOR:  base_res = op1 ^ op2;
         OP_SLL:  base_res = op1 << shamt;
         OP_SRA:  base_res = $unsigned($signed(op1) >>> shamt);
         OP_SRL:  base_res = op1 >> shamt;
         OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
         default: base_res = '0;
      endcase
   end

   // operand signedness and magnitudes for the iterative M datapath
   always_comb begin
      m_s1 = (op[2:0] == FN_MULH) || (op[2:0] == FN_MULHSU) ||
             (op[2:0] == FN_DIV)  || (op[2:0] == FN_REM);
      m_s2 = (op[2:0] == FN_MULH) || (op[2:0] == FN_DIV) || (op[2:0] == FN_REM);
      neg1 = m_s1 && op1[XLEN-1];
      neg2 = m_s2 && op2[XLEN-1];
      mag1 = neg1 ? (~op1 + 1'b1) : op1;
      mag2 = neg2 ? (~op2 + 1'b1) : op2;
   end

   // one iteration step of shift-add multiply and restoring divide
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_rs   = {hi_q, lo_q[XLEN-1]};
      div_diff = div_rs - {1'b0, b_q};
      div_ge   = !div_diff[XLEN];
   end

   // sign correction and half/quotient/remainder select
   always_comb begin
      prod_s  = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
      quot    = dz_q ? '1 : (neg_q ? (~lo_q + 1'b1) : lo_q);
      rem     = rneg_q ? (~hi_q + 1'b1) : hi_q;
      fin_res = '0;
      case (fn_q)
         FN_MUL:                      fin_res = prod_s[XLEN-1:0];
         FN_MULH, FN_MULHSU, FN_MULHU: fin_res = prod_s[2*XLEN-1:XLEN];
         FN_DIV, FN_DIVU:             fin_res = quot;
         default:                     fin_res = rem;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (!op[4])     state_d = S_DONE;
               else if (op[2]) state_d = S_DIV;
               else            state_d = S_MUL;
            end
         end
         S_MUL, S_DIV: if (cnt_q == CNTW'(1)) state_d = S_FIN;
         S_FIN:        state_d = S_DONE;
         S_DONE:       if (out_ready) state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   // handshake outputs decoded from state
   always_comb begin
      in_ready  = (state_q == S_IDLE) && !rst;
      busy      = (state_q != S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   // datapath next values
   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      fn_d     = fn_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!op[4]) begin
                  result_d = base_res;
               end else begin
                  // lo holds multiplier or dividend, b holds multiplicand or divisor
                  hi_d   = '0;
                  lo_d   = mag1;
                  b_d    = mag2;
                  cnt_d  = CNTW'(XLEN);
                  fn_d   = op[2:0];
                  neg_d  = neg1 ^ neg2;
                  rneg_d = neg1;
                  dz_d   = (op2 == '0);
               end
            end
         end
         S_MUL: begin
            hi_d  = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
            cnt_d = cnt_q - 1'b1;
         end
         S_DIV: begin
            hi_d  = div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], div_ge};
            cnt_d = cnt_q - 1'b1;
         end
         S_FIN: result_d = fin_res;
         default: ;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         fn_q     <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         fn_q     <= fn_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu at XLEN=32 and XLEN=8
// against an arithmetic reference model.
module tb_seq_alu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        iv32, ir32, ov32, ordy32, busy32;
   logic [4:0]  op32;
   logic [31:0] a32, b32, res32;
   logic        iv8, ir8, ov8, ordy8, busy8;
   logic [4:0]  op8;
   logic [7:0]  a8, b8, res8;

   int checks = 0;
   int errors = 0;

   seq_alu #(.XLEN(32)) u32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op32),
      .op1(a32), .op2(b32), .out_valid(ov32), .out_ready(ordy32),
      .result(res32), .busy(busy32)
   );

   seq_alu #(.XLEN(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op8),
      .op1(a8), .op2(b8), .out_valid(ov8), .out_ready(ordy8),
      .result(res8), .busy(busy8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference: plain signed/unsigned 64-bit arithmetic on w-bit values
   function automatic logic [31:0] model(input int w, input logic [4:0] f,
                                         input logic [31:0] a, input logic [31:0] b);
      longint mask, ua, ub, sa, sb, mn, r;
      int sh;
      mask = (longint'(1) << w) - 1;
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      mn   = longint'(1) << (w - 1);
      sa   = (ua >= mn) ? ua - (longint'(1) << w) : ua;
      sb   = (ub >= mn) ? ub - (longint'(1) << w) : ub;
      sh   = int'(ub % longint'(w));
      r    = 0;
      if (!f[4]) begin
         case (f[3:0])
            4'd0: r = ua + ub;
            4'd1: r = ua - ub;
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = ua << sh;
            4'd6: r = sa >>> sh;
            4'd7: r = ua >> sh;
            4'd8: r = (sa < sb) ? 1 : 0;
            4'd9: r = (ua < ub) ? 1 : 0;
            default: r = 0;
         endcase
      end else begin
         case (f[2:0])
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: r = (ua * ub) >> w;
            3'd4: r = (ub == 0) ? -1 : ((sa == -mn && sb == -1) ? sa : sa / sb);
            3'd5: r = (ub == 0) ? -1 : ua / ub;
            3'd6: r = (ub == 0) ? sa : ((sa == -mn && sb == -1) ? 0 : sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
         endcase
      end
      return 32'(r & mask);
   endfunction

   // issue one request at a negedge, wait for the result, check latency and value
   task automatic run(input bit n8, input logic [4:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input bit hold,
                      input string tag);
      int lat, cyc;
      bit rdy_seen;
      lat = f[4] ? (n8 ? 10 : 34) : 1;
      if (n8) begin iv8 = 1'b1; op8 = f; a8 = a[7:0]; b8 = b[7:0]; end
      else    begin iv32 = 1'b1; op32 = f; a32 = a; b32 = b; end
      chk({tag, "/in_ready"}, {31'b0, (n8 ? ir8 : ir32)}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      // drop the request and disturb operands; result must not depend on them
      iv8 = 1'b0; iv32 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
      cyc = 1;
      rdy_seen = 1'b0;
      while (!(n8 ? ov8 : ov32) && cyc < 60) begin
         if (n8 ? ir8 : ir32) rdy_seen = 1'b1;
         @(negedge clk);
         cyc++;
      end
      chk({tag, "/latency"}, 32'(cyc), 32'(lat));
      chk({tag, "/result"}, (n8 ? {24'b0, res8} : res32), exp);
      chk({tag, "/ready_low"}, {31'b0, rdy_seen}, 32'd0);
      if (!hold) begin
         @(negedge clk);
         chk({tag, "/valid_drop"}, {31'b0, (n8 ? ov8 : ov32)}, 32'd0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  f;
      logic [31:0] a, b, held;
      bit          seen;
      rst = 1'b1;
      iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; ordy32 = 1'b1;
      iv8  = 1'b0; op8  = '0; a8  = '0; b8  = '0; ordy8  = 1'b1;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst/in_ready", {31'b0, ir32}, 32'd0);
      chk("rst/out_valid", {31'b0, ov32}, 32'd0);
      chk("rst/result", res32, 32'd0);
      chk("rst/busy", {31'b0, busy32}, 32'd0);
      chk("rst/in_ready8", {31'b0, ir8}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst/in_ready", {31'b0, ir32}, 32'd1);
      @(negedge clk);

      // base ops, latency 1
      run(0, 5'b00001, 32'd5, 32'd7, 32'hFFFFFFFE, 0, "sub");
      run(0, 5'b00110, 32'h80000000, 32'd4, 32'hF8000000, 0, "sra");
      run(0, 5'b01000, 32'hFFFFFFFF, 32'd1, 32'd1, 0, "slt");
      run(0, 5'b01001, 32'hFFFFFFFF, 32'd1, 32'd0, 0, "sltu");
      run(0, 5'b01111, 32'h12345678, 32'h9ABCDEF0, 32'd0, 0, "undef");

      // multiply family
      run(0, 5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 0, "mul");
      run(0, 5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 0, "mulh");
      run(0, 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu");
      run(0, 5'b10010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0, "mulhsu");
      run(0, 5'b11011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu_op3");

      // division, including divide-by-zero and signed overflow
      run(0, 5'b10100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, "div");
      run(0, 5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, "rem");
      run(0, 5'b10101, 32'd7, 32'd0, 32'hFFFFFFFF, 0, "divu_z");
      run(0, 5'b10111, 32'd7, 32'd0, 32'd7, 0, "remu_z");
      run(0, 5'b10100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 0, "div_z");
      run(0, 5'b10110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 0, "rem_z");
      run(0, 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf");
      run(0, 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, "rem_ovf");

      // backpressure: result held, in_valid ignored, one accept afterwards
      ordy32 = 1'b0;
      run(0, 5'b10101, 32'd100, 32'd7, 32'd14, 1, "bp");
      held = res32;
      for (int i = 0; i < 10; i++) begin
         iv32 = i[0]; op32 = 5'b00000; a32 = 32'd1; b32 = 32'd1;
         @(negedge clk);
         chk("bp/out_valid", {31'b0, ov32}, 32'd1);
         chk("bp/result", res32, held);
         chk("bp/in_ready", {31'b0, ir32}, 32'd0);
      end
      iv32 = 1'b0;
      ordy32 = 1'b1;
      @(negedge clk);
      chk("bp/release", {31'b0, ov32}, 32'd0);
      run(0, 5'b00000, 32'd3, 32'd4, 32'd7, 0, "bp_next");
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (ov32) seen = 1'b1;
      end
      chk("bp/no_extra", {31'b0, seen}, 32'd0);

      // reset in the middle of a divide
      iv32 = 1'b1; op32 = 5'b10100; a32 = 32'd1000; b32 = 32'd3;
      @(posedge clk);
      @(negedge clk);
      iv32 = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid/busy", {31'b0, busy32}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid/out_valid", {31'b0, ov32}, 32'd0);
      chk("mid/busy_after", {31'b0, busy32}, 32'd0);
      rst = 1'b0;
      #1;
      chk("mid/in_ready", {31'b0, ir32}, 32'd1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ov32) seen = 1'b1;
      end
      chk("mid/no_result", {31'b0, seen}, 32'd0);

      // randomized 32-bit ops against the model
      for (int i = 0; i < 30; i++) begin
         f = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            1: begin a = $urandom; b = 32'd0; end
            2: begin a = 32'($urandom_range(0, 20)) - 32'd10; b = 32'($urandom_range(0, 6)) - 32'd3; end
            default: begin a = $urandom; b = $urandom; end
         endcase
         run(0, f, a, b, model(32, f, a, b), 0, "rnd32");
      end

      // XLEN=8 instance
      run(1, 5'b10011, 32'hFF, 32'hFF, 32'hFE, 0, "mulhu8");
      run(1, 5'b10100, 32'h80, 32'hFF, 32'h80, 0, "div_ovf8");
      run(1, 5'b00110, 32'h80, 32'h0B, 32'hF0, 0, "sra8");
      for (int i = 0; i < 20; i++) begin
         f = 5'($urandom_range(0, 31));
         a = 32'($urandom_range(0, 255));
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
         run(1, f, a, b, model(8, f, a, b), 0, "rnd8");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU.
- Covers the full RV32I integer op set, including SRA, SLT and SLTU.
- Adds the RV32M multiply/divide ops, executed iteratively.
- Sits in the execute stage between operand fetch/forwarding and writeback. The pipeline stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, operand/result width. Must be a power of two, >= 8. Shift amount width is SHW = log2(XLEN).
- CNTW, log2(XLEN)+1, iteration counter width. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request valid; op/op1/op2 are sampled when in_valid & in_ready.
- in_ready  output  1  unit can accept a request. High only in IDLE.
- op  input  5  operation select. op[4]=0 selects a base op (op[3:0]); op[4]=1 selects an M op (op[2:0]).
- op1  input  XLEN  first operand (rs1).
- op2  input  XLEN  second operand (rs2/imm).
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  registered result; stable while out_valid is high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after; out_valid=0, result=0, busy=0; state=IDLE; counter=0.
- Base encodings (op[4]=0):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRA, 0111 SRL; the shift amount is op2[SHW-1:0].
  - 1000 SLT (signed), 1001 SLTU; the result is zero-extended 0/1.
  - Any other code gives result 0.
- M encodings (op[4]=1), by op[2:0]:
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH, 010 MULHSU, 011 MULHU: high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned product.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - op[3] is ignored.
- States: IDLE, MUL, DIV, FIN, DONE.
- IDLE, on accept:
  - Base op: compute combinationally, register into result, go to DONE. out_valid is high in the cycle after accept (latency 1).
  - M op: latch the operand magnitudes and sign flags, clear the accumulator, set counter=XLEN, go to MUL or DIV.
- MUL: radix-2 shift-add over a 2×XLEN-bit product, one bit per cycle. Decrement the counter; go to FIN when it reaches 0.
- DIV: restoring divide, one quotient bit per cycle. Same counter rule as MUL.
- FIN: apply sign correction, select the low/high half or quotient/remainder, register into result, go to DONE.
- M-op latency is fixed at XLEN+2 cycles from accept to out_valid, including the special cases below. Latency must be data-independent.
- DONE: out_valid=1. When out_ready=1, go to IDLE next cycle with out_valid=0. Back-to-back accept is therefore possible every latency+1 cycles.
- Division by zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = op1.
- Signed overflow (op1 = most-negative value, op2 = -1):
  - DIV gives op1.
  - REM gives 0.
- Signs:
  - The remainder takes the sign of the dividend.
  - The quotient is negated when the operand signs differ.
  - MULHSU treats op2 as unsigned.
- Handshake and input rules:
  - in_valid while busy is ignored; no request is queued.
  - Operands may change after accept without affecting the result.
- out_ready held low: out_valid and result hold indefinitely; no new request is accepted.
- rst during any state aborts the operation: IDLE next cycle, out_valid=0, the partial result is discarded.

Test Plan:
- XLEN=32, base sweep: SUB 5,7 -> 0xFFFFFFFE; SRA 0x80000000,4 -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0; op 01111 -> 0. Each out_valid exactly 1 cycle after accept.
- MUL family: MUL 0xFFFFFFFF,0xFFFFFFFF -> 1; MULH same -> 0; MULHU same -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF,2 -> 0xFFFFFFFF. out_valid exactly 34 cycles after accept; in_ready low throughout.
- Division: DIV -7,2 -> -3; REM -7,2 -> -1; DIVU 7,0 -> 0xFFFFFFFF; REMU 7,0 -> 7; DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM same -> 0. All at 34-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles after DONE. result and out_valid stay stable; in_valid pulses are ignored; one accept follows out_ready=1.
- Reset mid-operation: assert rst at cycle 10 of a DIV. The next cycle shows IDLE, in_ready=1, out_valid=0, and no spurious result afterward.
- XLEN=8 instance: MULHU 0xFF,0xFF -> 0xFE; DIV 0x80,0xFF -> 0x80. Latency is 10 cycles.
